// File: rtl/io_uart_pkg.sv
// rtl/io_uart_pkg.sv - register offsets, STATUS bit positions, FSM state types and oversample constant for io_uart.
package io_uart_pkg;

  localparam int REG_TXDATA  = 0;
  localparam int REG_RXDATA  = 1;
  localparam int REG_STATUS  = 2;
  localparam int REG_DIVISOR = 3;

  localparam int ST_TX_BUSY    = 0;
  localparam int ST_RX_VALID   = 1;
  localparam int ST_RX_OVERRUN = 2;
  localparam int ST_FRAME_ERR  = 3;

  localparam int OVERSAMPLE    = 16;
  localparam int RX_FIFO_DEPTH = 4;

  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] TICK_HALF = 4'(OVERSAMPLE / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

endpackage

// File: rtl/io_uart_baud.sv
// rtl/io_uart_baud.sv - oversample tick generator, one pulse every divisor+1 clocks.
module io_uart_baud (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] i_divisor,
  input  logic        i_restart,
  output logic        o_tick
);

  logic [15:0] r_cnt;

  assign o_tick = (r_cnt == i_divisor);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= 16'd0;
    end else if (i_restart || o_tick) begin
      r_cnt <= 16'd0;
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/io_uart.sv
// rtl/io_uart.sv - memory-mapped UART with TX/RX FSMs and 16x oversampling receiver.
// Define IO_UART_RX_FIFO_EN for a 4-entry RX FIFO instead of a single holding register.
module io_uart
  import io_uart_pkg::*;
#(
  parameter logic [15:0] CLK_DIV_RESET = 16'd26,
  parameter int          IO_ADDR_BITS  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [IO_ADDR_BITS-1:0] addressIO,
  input  logic [31:0]             dataInIO,
  output logic [31:0]             dataOutIO,
  input  logic                    wEnIO,
  output logic                    txd,
  input  logic                    rxd
);

  logic w_sel_tx, w_sel_rx, w_sel_st, w_sel_div;
  logic w_wr_tx, w_wr_st, w_wr_div;
  logic w_pop, w_clr_ovr, w_clr_fe;
  logic w_tick;
  logic w_unused;

  assign w_sel_tx  = (addressIO == IO_ADDR_BITS'(REG_TXDATA));
  assign w_sel_rx  = (addressIO == IO_ADDR_BITS'(REG_RXDATA));
  assign w_sel_st  = (addressIO == IO_ADDR_BITS'(REG_STATUS));
  assign w_sel_div = (addressIO == IO_ADDR_BITS'(REG_DIVISOR));
  assign w_wr_tx   = wEnIO && w_sel_tx;
  assign w_wr_st   = wEnIO && w_sel_st;
  assign w_wr_div  = wEnIO && w_sel_div;
  assign w_pop     = w_wr_st && dataInIO[ST_RX_VALID];
  assign w_clr_ovr = w_wr_st && dataInIO[ST_RX_OVERRUN];
  assign w_clr_fe  = w_wr_st && dataInIO[ST_FRAME_ERR];
  assign w_unused  = ^dataInIO[31:16];

  logic [15:0] r_div;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div <= CLK_DIV_RESET;
    end else if (w_wr_div) begin
      r_div <= dataInIO[15:0];
    end
  end

  io_uart_baud u_baud (
    .clk       (clk),
    .rst       (rst),
    .i_divisor (r_div),
    .i_restart (w_wr_div),
    .o_tick    (w_tick)
  );

  // ---------------- transmitter ----------------
  tx_state_e  r_tx_state, w_tx_next;
  logic [7:0] r_tx_data, r_tx_shift;
  logic [3:0] r_tx_cnt;
  logic [2:0] r_tx_bit;
  logic       w_tx_accept, w_tx_bit_end, w_tx_busy;

  assign w_tx_bit_end = w_tick && (r_tx_cnt == TICK_LAST);
  assign w_tx_busy    = (r_tx_state != TX_IDLE);

  always_comb begin
    w_tx_next   = r_tx_state;
    w_tx_accept = 1'b0;
    case (r_tx_state)
      TX_IDLE:  if (w_wr_tx) begin
                  w_tx_accept = 1'b1;
                  w_tx_next   = TX_START;
                end
      TX_START: if (w_tx_bit_end) w_tx_next = TX_DATA;
      TX_DATA:  if (w_tx_bit_end && r_tx_bit == 3'd7) w_tx_next = TX_STOP;
      TX_STOP:  if (w_tx_bit_end) w_tx_next = TX_IDLE;
      default:  w_tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_state <= TX_IDLE;
      r_tx_data  <= 8'd0;
      r_tx_shift <= 8'd0;
      r_tx_cnt   <= 4'd0;
      r_tx_bit   <= 3'd0;
    end else begin
      r_tx_state <= w_tx_next;
      if (w_tx_accept) begin
        r_tx_data  <= dataInIO[7:0];
        r_tx_shift <= dataInIO[7:0];
        r_tx_cnt   <= 4'd0;
        r_tx_bit   <= 3'd0;
      end else if (w_tx_busy && w_tick) begin
        r_tx_cnt <= r_tx_cnt + 4'd1;
        if (w_tx_bit_end && r_tx_state == TX_DATA) begin
          r_tx_shift <= {1'b0, r_tx_shift[7:1]};
          r_tx_bit   <= r_tx_bit + 3'd1;
        end
      end
    end
  end

  // Decoded straight from state so an async reset lifts the line in the same cycle.
  always_comb begin
    txd = 1'b1;
    case (r_tx_state)
      TX_START: txd = 1'b0;
      TX_DATA:  txd = r_tx_shift[0];
      default:  txd = 1'b1;
    endcase
  end

  // ---------------- receiver ----------------
  rx_state_e  r_rx_state, w_rx_next;
  logic [1:0] r_rx_sync;
  logic       r_rx_prev;
  logic [3:0] r_rx_cnt;
  logic [2:0] r_rx_bit;
  logic [7:0] r_rx_shift;
  logic       w_rxd_s, w_rx_hit, w_rx_done;

  assign w_rxd_s  = r_rx_sync[1];
  assign w_rx_hit = w_tick && (r_rx_cnt == ((r_rx_state == RX_START) ? TICK_HALF : TICK_LAST));

  always_comb begin
    w_rx_next = r_rx_state;
    w_rx_done = 1'b0;
    case (r_rx_state)
      RX_IDLE:  if (r_rx_prev && !w_rxd_s) w_rx_next = RX_START;
      RX_START: if (w_rx_hit) w_rx_next = w_rxd_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_rx_hit && r_rx_bit == 3'd7) w_rx_next = RX_STOP;
      RX_STOP:  if (w_rx_hit) begin
                  w_rx_next = RX_IDLE;
                  w_rx_done = 1'b1;
                end
      default:  w_rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_state <= RX_IDLE;
      r_rx_sync  <= 2'b11;
      r_rx_prev  <= 1'b1;
      r_rx_cnt   <= 4'd0;
      r_rx_bit   <= 3'd0;
      r_rx_shift <= 8'd0;
    end else begin
      r_rx_state <= w_rx_next;
      r_rx_sync  <= {r_rx_sync[0], rxd};
      r_rx_prev  <= w_rxd_s;
      if (r_rx_state == RX_IDLE) begin
        r_rx_cnt <= 4'd0;
        r_rx_bit <= 3'd0;
      end else if (w_tick) begin
        r_rx_cnt <= w_rx_hit ? 4'd0 : r_rx_cnt + 4'd1;
        if (w_rx_hit && r_rx_state == RX_DATA) begin
          r_rx_shift <= {w_rxd_s, r_rx_shift[7:1]};
          r_rx_bit   <= r_rx_bit + 3'd1;
        end
      end
    end
  end

  // ---------------- RX storage ----------------
  logic       w_rx_valid, w_rx_drop, w_do_push;
  logic [7:0] w_rx_head;

`ifdef IO_UART_RX_FIFO_EN
  logic [7:0] r_fifo [RX_FIFO_DEPTH];
  logic [1:0] r_wr_ptr, r_rd_ptr;
  logic [2:0] r_count;
  logic       w_do_pop;

  assign w_do_pop   = w_pop && (r_count != 3'd0);
  assign w_do_push  = w_rx_done && ((r_count - 3'(w_do_pop)) != 3'(RX_FIFO_DEPTH));
  assign w_rx_drop  = w_rx_done && !w_do_push;
  assign w_rx_valid = (r_count != 3'd0);
  assign w_rx_head  = r_fifo[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) r_fifo[r_wr_ptr] <= r_rx_shift;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      r_count  <= 3'd0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 2'd1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
      r_count <= r_count + 3'(w_do_push) - 3'(w_do_pop);
    end
  end
`else
  logic [7:0] r_hold;
  logic       r_hold_valid;

  // A pop in the same cycle frees the register for the completing byte.
  assign w_do_push  = w_rx_done && (!r_hold_valid || w_pop);
  assign w_rx_drop  = w_rx_done && !w_do_push;
  assign w_rx_valid = r_hold_valid;
  assign w_rx_head  = r_hold;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hold       <= 8'd0;
      r_hold_valid <= 1'b0;
    end else if (w_do_push) begin
      r_hold       <= r_rx_shift;
      r_hold_valid <= 1'b1;
    end else if (w_pop) begin
      r_hold_valid <= 1'b0;
    end
  end
`endif

  logic r_overrun, r_frame_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_rx_drop)      r_overrun <= 1'b1;
      else if (w_clr_ovr) r_overrun <= 1'b0;
      if (w_rx_done && !w_rxd_s) r_frame_err <= 1'b1;
      else if (w_clr_fe)         r_frame_err <= 1'b0;
    end
  end

  always_comb begin
    dataOutIO = 32'd0;
    if (w_sel_tx) begin
      dataOutIO[7:0] = r_tx_data;
    end else if (w_sel_rx) begin
      dataOutIO[7:0] = w_rx_valid ? w_rx_head : 8'd0;
    end else if (w_sel_st) begin
      dataOutIO[ST_TX_BUSY]    = w_tx_busy;
      dataOutIO[ST_RX_VALID]   = w_rx_valid;
      dataOutIO[ST_RX_OVERRUN] = r_overrun;
      dataOutIO[ST_FRAME_ERR]  = r_frame_err;
    end else if (w_sel_div) begin
      dataOutIO[15:0] = r_div;
    end
  end

endmodule
